// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet S2->C3 datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// F2_*  : S2 feature-map buffer geometry (14x14, 6 channels, 16b samples).
// C3_*  : C3 kernel size and resulting output grid edge.
package lenet_pkg;

  localparam int F2_W   = 14;
  localparam int F2_CH  = 6;
  localparam int C3_K   = 5;
  localparam int C3_OUT = F2_W - C3_K + 1;
  localparam int F2_DW  = 16;
  localparam int F2_AW  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  // Per-beat markers that travel with the data from address issue to output.
  typedef struct packed {
    logic tap_last;
    logic frame_last;
  } tap_tag_t;

endpackage

// File: rtl/f2_tap_fifo.sv
// Two-entry FIFO holding tap beats (data + tags) between the RAM and the consumer.
// Latency: written entry is visible on dout the cycle after push when empty.
// Backpressure: caller must not push when full unless popping in the same cycle.
//
// Ports: clk, rst (async, active high), push/din, pop, dout (head entry),
//        count (0..2), empty, full.
module f2_tap_fifo #(
  parameter int W = 98
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count    <= 2'd0;
    end else begin
      // A push while full only happens together with a pop; the slot being
      // overwritten is then the head that leaves on this same edge.
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head stays put until popped, so outputs are stable under backpressure.
  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/f2_window_reader.sv
// Reads the S2 map and streams 5x5 C3 receptive-field taps, 6 channels per beat.
// Latency: start edge E0 -> f2_raddr valid after E0 -> beat in FIFO at E2 -> tap_valid.
// Backpressure: tap_valid/tap_ready; outputs frozen while stalled, reads throttled.
//
// Ports: clk, rst (async, active high); start/busy/done frame control;
//        f2_raddr + f2_n_rdata (n=1..6) to the synchronous RAM;
//        tap_n_data, tap_valid, tap_ready, tap_last, frame_last to the MAC array.
module f2_window_reader
  import lenet_pkg::*;
#(
  parameter int IMG_W = F2_W,
  parameter int K     = C3_K,
  parameter int DW    = F2_DW,
  parameter int AW    = F2_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] f2_raddr,
  input  logic [DW-1:0] f2_1_rdata,
  input  logic [DW-1:0] f2_2_rdata,
  input  logic [DW-1:0] f2_3_rdata,
  input  logic [DW-1:0] f2_4_rdata,
  input  logic [DW-1:0] f2_5_rdata,
  input  logic [DW-1:0] f2_6_rdata,
  output logic [DW-1:0] tap_1_data,
  output logic [DW-1:0] tap_2_data,
  output logic [DW-1:0] tap_3_data,
  output logic [DW-1:0] tap_4_data,
  output logic [DW-1:0] tap_5_data,
  output logic [DW-1:0] tap_6_data,
  output logic          tap_valid,
  input  logic          tap_ready,
  output logic          tap_last,
  output logic          frame_last
);

  localparam int OUT = IMG_W - K + 1;
  localparam int RCW = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int FW  = F2_CH * DW + 2;

  localparam logic [RCW-1:0] RC_MAX   = RCW'(OUT - 1);
  localparam logic [KW-1:0]  K_MAX    = KW'(K - 1);
  localparam logic [AW-1:0]  ROW_STEP = AW'(IMG_W);

  rd_state_t state_q, state_d;

  logic [RCW-1:0] r_q, c_q;
  logic [KW-1:0]  kr_q, kc_q;
  logic [AW-1:0]  win_base_q;   // r*IMG_W
  logic [AW-1:0]  tap_base_q;   // (r+kr)*IMG_W

  // Two read stages: address registered (a), then RAM output valid (d).
  logic     inflight_a_q, inflight_d_q;
  tap_tag_t tag_a_q, tag_d_q, issue_tag, head_tag;

  logic          issue, finish, pop, push, room, drain_done;
  logic          win_end, frame_end;
  logic [2:0]    outstanding;
  logic [1:0]    fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic [FW-1:0] fifo_din, fifo_dout;

  assign pop       = tap_valid && tap_ready;
  assign push      = inflight_d_q && (!fifo_full || pop);
  assign win_end   = (kr_q == K_MAX) && (kc_q == K_MAX);
  assign frame_end = win_end && (r_q == RC_MAX) && (c_q == RC_MAX);
  assign issue_tag = '{tap_last: win_end, frame_last: frame_end};

  // The RAM output register is a third storage slot: when the FIFO is full the
  // data stage simply waits, and since no new address is issued meanwhile the
  // RAM keeps re-reading the same word. So up to 3 beats may be outstanding.
  assign outstanding = 3'(fifo_cnt) + 3'(inflight_a_q) + 3'(inflight_d_q);
  assign room        = (outstanding - 3'(pop)) < 3'd3;
  assign drain_done  = !inflight_a_q && !inflight_d_q && (fifo_cnt == {1'b0, pop});

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // done is high only in the first IDLE cycle; start is ignored there.
        if (start && !done) begin
          issue   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (room) begin
          issue = 1'b1;
          if (frame_end) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= finish;
    end
  end

  assign busy = (state_q != ST_IDLE);

  // Scan counters and address: addr = tap_base + c + kc, all incremental.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q        <= '0;
      c_q        <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      win_base_q <= '0;
      tap_base_q <= '0;
      f2_raddr   <= '0;
    end else if (issue) begin
      f2_raddr <= tap_base_q + AW'(c_q) + AW'(kc_q);
      if (kc_q != K_MAX) begin
        kc_q <= kc_q + KW'(1);
      end else begin
        kc_q <= '0;
        if (kr_q != K_MAX) begin
          kr_q       <= kr_q + KW'(1);
          tap_base_q <= tap_base_q + ROW_STEP;
        end else begin
          kr_q <= '0;
          if (c_q != RC_MAX) begin
            c_q        <= c_q + RCW'(1);
            tap_base_q <= win_base_q;
          end else begin
            c_q <= '0;
            if (r_q != RC_MAX) begin
              r_q        <= r_q + RCW'(1);
              win_base_q <= win_base_q + ROW_STEP;
              tap_base_q <= win_base_q + ROW_STEP;
            end else begin
              // Frame complete: counters wrap so the next start begins at 0.
              r_q        <= '0;
              win_base_q <= '0;
              tap_base_q <= '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_a_q <= 1'b0;
      inflight_d_q <= 1'b0;
      tag_a_q      <= '0;
      tag_d_q      <= '0;
    end else begin
      inflight_a_q <= issue;
      if (issue) tag_a_q <= issue_tag;
      // The data stage only holds while the FIFO is full, which also blocks
      // issue, so the address stage is empty whenever it holds.
      if (!inflight_d_q || push) begin
        inflight_d_q <= inflight_a_q;
        tag_d_q      <= tag_a_q;
      end
    end
  end

  assign fifo_din = {f2_6_rdata, f2_5_rdata, f2_4_rdata,
                     f2_3_rdata, f2_2_rdata, f2_1_rdata, tag_d_q};

  f2_tap_fifo #(
    .W(FW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (fifo_din),
    .pop  (pop),
    .dout (fifo_dout),
    .count(fifo_cnt),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign {tap_6_data, tap_5_data, tap_4_data,
          tap_3_data, tap_2_data, tap_1_data} = fifo_dout[FW-1:2];
  assign head_tag   = tap_tag_t'(fifo_dout[1:0]);
  assign tap_valid  = !fifo_empty;
  assign tap_last   = tap_valid && head_tag.tap_last;
  assign frame_last = tap_valid && head_tag.frame_last;

endmodule

// File: tb/tb_f2_window_reader.sv
// Self-checking bench for f2_window_reader with a 1-cycle synchronous RAM model.
// Latency: n/a.
// Backpressure: tap_ready driven constant, random, or stalled per scenario.
module tb_f2_window_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        tap_ready;
  logic        busy, done;
  logic [9:0]  f2_raddr;
  logic [15:0] f2_1_rdata, f2_2_rdata, f2_3_rdata, f2_4_rdata, f2_5_rdata, f2_6_rdata;
  logic [15:0] tap_1_data, tap_2_data, tap_3_data, tap_4_data, tap_5_data, tap_6_data;
  logic        tap_valid, tap_last, frame_last;

  int n_checks = 0;
  int n_errors = 0;
  int beat_cnt = 0, tlast_cnt = 0, flast_cnt = 0, done_cnt = 0;
  int cyc = 0, last_hs_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [97:0] prev_val;
  logic [97:0] exp_q[$];

  always #5 clk = ~clk;

  // RAM: channel n word at address a is a + 256*(n-1).
  always @(posedge clk) begin
    f2_1_rdata <= 16'(f2_raddr);
    f2_2_rdata <= 16'(f2_raddr) + 16'd256;
    f2_3_rdata <= 16'(f2_raddr) + 16'd512;
    f2_4_rdata <= 16'(f2_raddr) + 16'd768;
    f2_5_rdata <= 16'(f2_raddr) + 16'd1024;
    f2_6_rdata <= 16'(f2_raddr) + 16'd1280;
  end

  f2_window_reader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .f2_raddr(f2_raddr),
    .f2_1_rdata(f2_1_rdata), .f2_2_rdata(f2_2_rdata), .f2_3_rdata(f2_3_rdata),
    .f2_4_rdata(f2_4_rdata), .f2_5_rdata(f2_5_rdata), .f2_6_rdata(f2_6_rdata),
    .tap_1_data(tap_1_data), .tap_2_data(tap_2_data), .tap_3_data(tap_3_data),
    .tap_4_data(tap_4_data), .tap_5_data(tap_5_data), .tap_6_data(tap_6_data),
    .tap_valid(tap_valid), .tap_ready(tap_ready),
    .tap_last(tap_last), .frame_last(frame_last)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [97:0] cur_beat();
    return {tap_6_data, tap_5_data, tap_4_data, tap_3_data, tap_2_data, tap_1_data,
            tap_last, frame_last};
  endfunction

  function automatic logic [110:0] all_outs();
    return {busy, done, tap_valid, tap_last, frame_last, f2_raddr,
            tap_6_data, tap_5_data, tap_4_data, tap_3_data, tap_2_data, tap_1_data};
  endfunction

  task automatic push_frame();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        for (int kr = 0; kr < 5; kr++)
          for (int kc = 0; kc < 5; kc++) begin
            logic [15:0] a;
            logic        tl, fl;
            a  = 16'((r + kr) * 14 + c + kc);
            tl = (kr == 4) && (kc == 4);
            fl = tl && (r == 9) && (c == 9);
            exp_q.push_back({a + 16'd1280, a + 16'd1024, a + 16'd768,
                             a + 16'd512, a + 16'd256, a, tl, fl});
          end
  endtask

  task automatic monitor_step();
    if (rst) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      check("hold_valid", 128'(tap_valid), 128'd1);
      check("hold_data", 128'(cur_beat()), 128'(prev_val));
    end
    if (tap_valid && tap_ready) begin
      check("beat_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) check("beat", 128'(cur_beat()), 128'(exp_q.pop_front()));
      beat_cnt++;
      tlast_cnt += int'(tap_last);
      flast_cnt += int'(frame_last);
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      check("done_latency", 128'(cyc), 128'(last_hs_cyc + 1));
    end
    prev_stall = tap_valid && !tap_ready;
    prev_val   = cur_beat();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    step();
    start = 1'b1;
    push_frame();
    step();          // this edge is E0
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    while (!done && n < budget) begin
      step();
      if (rnd) tap_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("done_seen", 128'(done), 128'd1);
    check("busy_in_done", 128'(busy), 128'd0);
    tap_ready = 1'b1;
  endtask

  task automatic frame_summary(input string tag, input int b0, input int t0, input int f0,
                               input int d0);
    step();
    check({tag, "_done_width"}, 128'(done), 128'd0);
    check({tag, "_beats"}, 128'(beat_cnt - b0), 128'd2500);
    check({tag, "_tap_last"}, 128'(tlast_cnt - t0), 128'd100);
    check({tag, "_frame_last"}, 128'(flast_cnt - f0), 128'd1);
    check({tag, "_done_cnt"}, 128'(done_cnt - d0), 128'd1);
    check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int b0, t0, f0, d0, n;
    bit p1;
    fork
      forever begin @(posedge clk); cyc++; end
      forever begin @(negedge clk); monitor_step(); end
    join_none

    rst = 1'b1; start = 1'b0; tap_ready = 1'b0;
    #22;
    check("rst_outputs", 128'(all_outs()), 128'd0);
    rst = 1'b0;

    // 1: full frame, ready=1, first-beat latency.
    tap_ready = 1'b1;
    b0 = beat_cnt; t0 = tlast_cnt; f0 = flast_cnt; d0 = done_cnt;
    start_frame();
    check("s1_busy_e0", 128'(busy), 128'd1);
    check("s1_raddr_e0", 128'(f2_raddr), 128'd0);
    check("s1_valid_e0", 128'(tap_valid), 128'd0);
    step();
    check("s1_valid_e1", 128'(tap_valid), 128'd0);
    check("s1_raddr_e1", 128'(f2_raddr), 128'd1);
    step();
    check("s1_valid_e2", 128'(tap_valid), 128'd1);
    check("s1_first_ch1", 128'(tap_1_data), 128'd0);
    wait_done(6000, 1'b0);
    frame_summary("s1", b0, t0, f0, d0);
    check("s1_busy_after", 128'(busy), 128'd0);

    // 2: random backpressure.
    b0 = beat_cnt; t0 = tlast_cnt; f0 = flast_cnt; d0 = done_cnt;
    start_frame();
    wait_done(20000, 1'b1);
    frame_summary("s2", b0, t0, f0, d0);

    // 3: stall 20 cycles at the first beat.
    tap_ready = 1'b0;
    b0 = beat_cnt; t0 = tlast_cnt; f0 = flast_cnt; d0 = done_cnt;
    start_frame();
    n = 0;
    while (!tap_valid && n < 10) begin step(); n++; end
    check("s3_valid_seen", 128'(tap_valid), 128'd1);
    repeat (20) step();
    check("s3_reads_bounded", 128'(f2_raddr <= 10'd2), 128'd1);
    check("s3_frozen_ch1", 128'(tap_1_data), 128'd0);
    check("s3_no_beats", 128'(beat_cnt - b0), 128'd0);
    tap_ready = 1'b1;
    wait_done(6000, 1'b0);
    frame_summary("s3", b0, t0, f0, d0);

    // 4: start pulses at beat 500 and in the done cycle are ignored.
    b0 = beat_cnt; t0 = tlast_cnt; f0 = flast_cnt; d0 = done_cnt;
    start_frame();
    p1 = 1'b0; n = 0;
    while (!done && n < 6000) begin
      step();
      start = 1'b0;
      if (!done && !p1 && (beat_cnt - b0) >= 500) begin start = 1'b1; p1 = 1'b1; end
      n++;
    end
    check("s4_done_seen", 128'(done), 128'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();
    check("s4_busy", 128'(busy), 128'd0);
    check("s4_valid", 128'(tap_valid), 128'd0);
    check("s4_beats", 128'(beat_cnt - b0), 128'd2500);
    check("s4_done_cnt", 128'(done_cnt - d0), 128'd1);
    check("s4_queue_empty", 128'(exp_q.size()), 128'd0);

    // 5: reset at beat 1000, then a clean frame.
    b0 = beat_cnt; d0 = done_cnt;
    start_frame();
    n = 0;
    while ((beat_cnt - b0) < 1000 && n < 6000) begin step(); n++; end
    check("s5_reached_1000", 128'((beat_cnt - b0) >= 1000), 128'd1);
    #2 rst = 1'b1;
    #1 check("s5_rst_async", 128'(all_outs()), 128'd0);
    exp_q.delete();
    step();
    check("s5_rst_held", 128'(all_outs()), 128'd0);
    #2 rst = 1'b0;
    repeat (5) step();
    check("s5_no_done", 128'(done_cnt - d0), 128'd0);
    check("s5_idle", 128'(busy), 128'd0);
    b0 = beat_cnt; t0 = tlast_cnt; f0 = flast_cnt; d0 = done_cnt;
    start_frame();
    wait_done(6000, 1'b0);
    frame_summary("s5", b0, t0, f0, d0);

    // 6: stall on the final beat for 5 cycles.
    b0 = beat_cnt; t0 = tlast_cnt; f0 = flast_cnt; d0 = done_cnt;
    start_frame();
    n = 0;
    while (!(tap_valid && frame_last) && n < 6000) begin step(); n++; end
    check("s6_frame_last_seen", 128'(frame_last), 128'd1);
    tap_ready = 1'b0;
    repeat (5) begin
      step();
      check("s6_frame_last_held", 128'(frame_last), 128'd1);
      check("s6_no_early_done", 128'(done), 128'd0);
    end
    tap_ready = 1'b1;
    wait_done(20, 1'b0);
    frame_summary("s6", b0, t0, f0, d0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
